// File: rtl/rf_pkg.sv
// Shared constants for the two-read one-write register file.
// Optional same-edge write-to-read forwarding: define RF_BYPASS_EN.
package rf_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = $clog2(RF_DEPTH);
  localparam int RF_ZERO  = 0;

endpackage

// File: rtl/rf_word.sv
// One register-file storage word: enabled load, async active-low clear.
module rf_word
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read one-write register file with registered read ports.
// Define RF_BYPASS_EN to forward same-edge write data to the readers.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH,
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign word_q[RF_ZERO] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_word
    rf_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .en  (wr_en && (wr_addr == AW'(i))),
      .d   (wr_data),
      .q   (word_q[i])
    );
  end

  always_comb begin
    rd_a = word_q[rd_addr_a];
    rd_b = word_q[rd_addr_b];
`ifdef RF_BYPASS_EN
    // word 0 is never forwarded, it must keep reading zero
    if (wr_en && wr_addr != AW'(RF_ZERO)) begin
      if (wr_addr == rd_addr_a) rd_a = wr_data;
      if (wr_addr == rd_addr_b) rd_b = wr_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data_a <= rd_a;
        rd_data_b <= rd_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        rd_valid;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_byp;

  reg_file_2r1w dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_valid  (rd_valid),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_req = 1'b1; rd_addr_a = a; rd_addr_b = b;
  endtask

  task automatic idle;
    wr_en = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0;
    rd(5'd5, 5'd31);
    #12;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_a", rd_data_a, 32'h0);
    chk("rst_b", rd_data_b, 32'h0);
    rst = 1'b1;
    tick();
    chk("first_valid", 32'(rd_valid), 32'd1);
    chk("first_a", rd_data_a, 32'h0);
    chk("first_b", rd_data_b, 32'h0);

    idle();
    wr(5'd7, 32'hDEADBEEF);
    tick();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    idle();
    rd(5'd7, 5'd0);
    tick();
    chk("w7_valid", 32'(rd_valid), 32'd1);
    chk("w7_a", rd_data_a, 32'hDEADBEEF);
    chk("w7_b0", rd_data_b, 32'h0);

    idle();
    wr(5'd0, 32'h12345678);
    tick();
    idle();
    rd(5'd0, 5'd7);
    tick();
    chk("w0_a", rd_data_a, 32'h0);
    chk("w0_keep7", rd_data_b, 32'hDEADBEEF);

    idle();
    wr(5'd3, 32'h11);
    tick();
    idle();
    wr(5'd3, 32'hA5A5A5A5);
    rd(5'd3, 5'd3);
    tick();
`ifdef RF_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h00000011;
`endif
    chk("byp_a", rd_data_a, exp_byp);
    chk("byp_b_eq", rd_data_b, exp_byp);
    idle();
    rd(5'd3, 5'd7);
    tick();
    chk("after_byp_a", rd_data_a, 32'hA5A5A5A5);
    chk("after_byp_b", rd_data_b, 32'hDEADBEEF);

    idle();
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    tick();
    chk("byp0_a", rd_data_a, 32'h0);
    chk("byp0_b", rd_data_b, 32'h0);

    idle();
    wr(5'd1, 32'h1);
    tick();
    wr(5'd2, 32'h2);
    tick();
    wr(5'd3, 32'h3);
    tick();
    idle();
    rd(5'd1, 5'd31);
    tick();
    chk("b2b1_valid", 32'(rd_valid), 32'd1);
    chk("b2b1_a", rd_data_a, 32'h1);
    rd(5'd2, 5'd1);
    tick();
    chk("b2b2_valid", 32'(rd_valid), 32'd1);
    chk("b2b2_a", rd_data_a, 32'h2);
    chk("b2b2_b", rd_data_b, 32'h1);
    rd(5'd3, 5'd2);
    tick();
    chk("b2b3_valid", 32'(rd_valid), 32'd1);
    chk("b2b3_a", rd_data_a, 32'h3);
    chk("b2b3_b", rd_data_b, 32'h2);
    idle();
    rd_addr_a = 5'd7;
    tick();
    chk("drop_valid", 32'(rd_valid), 32'd0);
    chk("drop_hold_a", rd_data_a, 32'h3);
    chk("drop_hold_b", rd_data_b, 32'h2);

    rd(5'd7, 5'd3);
    tick();
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    chk("pre_rst_a", rd_data_a, 32'hDEADBEEF);
    idle();
    wr(5'd9, 32'hCAFEF00D);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_a", rd_data_a, 32'h0);
    chk("mid_rst_b", rd_data_b, 32'h0);
    tick();
    idle();
    rst = 1'b1;
    rd(5'd7, 5'd9);
    tick();
    chk("post_rst_valid", 32'(rd_valid), 32'd1);
    chk("post_rst_a", rd_data_a, 32'h0);
    chk("post_rst_b", rd_data_b, 32'h0);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of words; address width is log2(DEPTH) = 5 at default.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst == 0 resets).
REQ-005 wr_en  input  1  write strobe.
REQ-006 wr_addr  input  5  write word index.
REQ-007 wr_data  input  WIDTH  write data.
REQ-008 rd_req  input  1  read request; both ports are read together.
REQ-009 rd_addr_a  input  5  port A word index.
REQ-010 rd_addr_b  input  5  port B word index.
REQ-011 rd_valid  output  1  read data valid, one-cycle pulse per accepted request.
REQ-012 rd_data_a  output  WIDTH  registered port A data.
REQ-013 rd_data_b  output  WIDTH  registered port B data.

Function
REQ-014 SHALL hold DEPTH words of WIDTH bits; word 0 always reads 0, and writes to it are discarded.
REQ-015 SHALL write wr_data to word wr_addr on a rising edge where wr_en = 1 and wr_addr != 0; the value is readable from the following edge.
REQ-016 SHALL sample rd_req, rd_addr_a and rd_addr_b on rising edge k; if rd_req = 1, SHALL drive rd_data_a/rd_data_b and rd_valid = 1 from edge k until edge k+1 (latency 1 cycle).
REQ-017 SHALL drive rd_valid = 0 after any edge where rd_req = 0, and rd_data_a/rd_data_b SHALL hold their last values.
REQ-018 Back-to-back requests SHALL give rd_valid = 1 on consecutive cycles, each carrying the data for its own addresses.
REQ-019 Ports A and B SHALL be independent; equal addresses SHALL return identical data.
REQ-020 Same-edge write and read of the same nonzero address SHALL follow the RF_BYPASS_EN rule in Configuration.
REQ-021 A write with wr_en = 1 and wr_addr = 0 SHALL change no state.

Reset
REQ-022 While rst = 0, SHALL clear every word to 0, rd_data_a = 0, rd_data_b = 0 and rd_valid = 0, independent of clk.
REQ-023 Reset asserted mid-operation SHALL drop any pending rd_valid pulse immediately and SHALL discard any same-edge write.
REQ-024 After rst rises, the first rising edge SHALL operate normally.

Configuration
REQ-025 Macro RF_BYPASS_EN defined: a read at edge k of the address written at edge k SHALL return the new wr_data; address 0 still returns 0.
REQ-026 Macro RF_BYPASS_EN undefined: that read SHALL return the pre-write contents, and the new value SHALL be visible from edge k+1.

Structure
REQ-027 WIDTH/DEPTH defaults, the address-width constant and the zero-word index SHALL live in the shared package rf_pkg.
REQ-028 Each storage word SHALL be one instance of sub-module rf_word (WIDTH-bit enabled register, asynchronous active-low clear), generated DEPTH-1 times; word 0 is a constant.
REQ-029 Read muxes, the bypass compare and the output registers SHALL live in reg_file_2r1w.

Verification
REQ-030 Reset with rst = 0, then release; read A = 5, B = 31 -> rd_valid = 1 one cycle later, both data = 0x00000000.
REQ-031 Write 0xDEADBEEF to 7, then next cycle read A = 7, B = 0 -> A = 0xDEADBEEF, B = 0.
REQ-032 Write 0x12345678 to 0, read A = 0 -> A = 0; no other word changed.
REQ-033 On the same edge, write 0xA5A5A5A5 to 3 (old value 0x11) and read A = 3 -> A = 0xA5A5A5A5 with RF_BYPASS_EN, 0x00000011 without it.
REQ-034 Issue three consecutive requests to words 1, 2, 3 holding 0x1, 0x2, 0x3 -> rd_valid high for 3 cycles, A = 0x1, 0x2, 0x3 in order; drop rd_req -> rd_valid = 0, data held at 0x3.
REQ-035 Pull rst = 0 the cycle after a read request while rd_valid = 1 -> rd_valid and data go to 0 immediately; a later read of a previously written word returns 0.
